nodf_module_handshake_tracker: RTL and testbench
================================================

Name: nodf_module_handshake_tracker

Overview:
- Passive, non-intrusive observer of one non-dataflow HLS block's ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue).
- Derives the block's run status and accumulates per-block statistics: transactions, latency, ready interval, busy and stall cycles.
- One instance per monitored block inside the simulation/debug monitor top; results are read by the CSV dump logic after finish.
- Unused or tied-off slots (inputs constant 0, or ready-only wiring) must remain well-behaved.

Parameters:
- CNT_W, 32, width of every counter and statistic output.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ap_start  in  1  monitored block start.
- ap_ready  in  1  monitored block ready (inputs consumed).
- ap_done  in  1  monitored block done.
- ap_continue  in  1  downstream continue; tie 1 for ap_ctrl_hs blocks.
- finish  in  1  end-of-simulation indication.
- state  out  2  0=IDLE, 1=RUN, 2=WAIT_CONT; 3 is unused.
- finished  out  1  sticky; set once finish has been sampled.
- done_pulse  out  1  one-cycle pulse per completed transaction.
- txn_count  out  CNT_W  completed transactions.
- ready_count  out  CNT_W  cycles with ap_ready=1.
- last_latency, min_latency, max_latency  out  CNT_W  start-to-done cycle counts.
- lat_valid  out  1  at least one latency has been recorded.
- last_interval  out  CNT_W  cycles between the two most recent ap_ready pulses.
- busy_cycles  out  CNT_W  cycles spent in RUN.
- stall_cycles  out  CNT_W  cycles spent in WAIT_CONT.

Behaviour:
- Timing: all outputs registered; inputs are sampled at posedge; each effect appears on outputs the cycle after it is sampled.
- Reset values:
  - state=IDLE.
  - All counters, last_latency, max_latency and last_interval = 0.
  - min_latency = all-ones.
  - finished, lat_valid, done_pulse = 0.
  - The internal latency counter, interval counter and "ready seen" flag are cleared.
- Reset has priority over every other input, including finish, and clears a sticky finished.
- Freeze: once finished=1, every state and statistic register holds its value until reset; done_pulse is 0. The cycle in which finish is sampled updates only finished.
- State machine (evaluated only while not finished):
  - IDLE, ap_start=1: start accepted; latency counter := 0; go to RUN. If ap_done=1 in the same cycle, complete immediately with latency 0 (the completion rules below apply).
  - RUN: busy_cycles++ and latency counter++ every cycle.
  - RUN, ap_done=1: completion.
    - ap_continue=1: go to RUN if ap_start=1 (back-to-back; latency counter restarts at 0), otherwise go to IDLE.
    - ap_continue=0: go to WAIT_CONT.
  - WAIT_CONT: stall_cycles++ each cycle. On ap_continue=1 go to RUN if ap_start=1, otherwise go to IDLE.
- Completion (taken once per transaction, on the done cycle even when continue is withheld):
  - txn_count++ and done_pulse=1.
  - last_latency := latency counter value in the done cycle.
  - min_latency and max_latency updated with that value; lat_valid := 1.
- ap_done outside RUN/IDLE-start is ignored. ap_start while in RUN is ignored except at completion.
- Ready tracking is independent of the state machine:
  - ready_count++ on every cycle ap_ready=1.
  - Interval counter increments every cycle and restarts at 1 the cycle after a ready.
  - On a ready with "ready seen" already set: last_interval := interval counter value. The first ready only sets "ready seen".
  - Consecutive ready cycles give last_interval=1.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Tied-off instance (all inputs 0): stays IDLE with all statistics at their reset values indefinitely.

Test Plan:
- Reset, then all inputs 0 for 50 cycles -> state=0, all counts 0, min_latency=0xFFFFFFFF, lat_valid=0.
- ap_continue=1; start 1 cycle; done 5 cycles after start -> last/min/max_latency=5, txn_count=1, busy_cycles=5, done_pulse high exactly 1 cycle, state back to 0.
- Done with ap_continue=0, continue raised 3 cycles later -> state=2 for 3 cycles, stall_cycles=3, txn_count=1 counted at the done cycle.
- Back-to-back transactions with latencies 4 and 7 (start held high at the first done) -> txn_count=2, min=4, max=7, last=7, state never visits IDLE in between.
- Ready-only wiring: ap_ready pulses at cycles 10, 16, 17 -> ready_count=3, last_interval=1 (after 6 was recorded first).
- finish asserted mid-RUN, then further start/done/ready activity -> finished=1, all outputs frozen; a subsequent reset clears everything.

Source files
------------

// File: rtl/nodf_module_handshake_tracker_if.sv
// ap_ctrl handshake bundle of one monitored HLS block.
// The tracker only observes it, so its slave modport is all inputs.
interface nodf_module_handshake_tracker_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (output ap_start, ap_ready, ap_done, ap_continue);
    modport slave  (input  ap_start, ap_ready, ap_done, ap_continue);
endinterface

// File: rtl/nodf_module_handshake_tracker.sv
// Passive ap_ctrl handshake observer: run status plus saturating per-block
// statistics, frozen once finish is seen so the dump logic reads stable values.
module nodf_module_handshake_tracker #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    nodf_module_handshake_tracker_if.slave     hs,
    input  logic                               finish,
    output logic [1:0]                         state,
    output logic                               finished,
    output logic                               done_pulse,
    output logic [CNT_W-1:0]                   txn_count,
    output logic [CNT_W-1:0]                   ready_count,
    output logic [CNT_W-1:0]                   last_latency,
    output logic [CNT_W-1:0]                   min_latency,
    output logic [CNT_W-1:0]                   max_latency,
    output logic                               lat_valid,
    output logic [CNT_W-1:0]                   last_interval,
    output logic [CNT_W-1:0]                   busy_cycles,
    output logic [CNT_W-1:0]                   stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           st_q, st_d;
    logic             finished_d, done_d, lat_valid_d, seen_q, seen_d;
    logic [CNT_W-1:0] txn_d, ready_d, last_lat_d, min_d, max_d, last_int_d;
    logic [CNT_W-1:0] busy_d, stall_d, lat_q, lat_d, int_q, int_d;
    logic             complete;
    logic [CNT_W-1:0] cur_lat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign state = st_q;

    // Next-state and statistics update; everything holds once finished
    always_comb begin
        st_d        = st_q;
        finished_d  = finished;
        done_d      = 1'b0;
        txn_d       = txn_count;
        ready_d     = ready_count;
        last_lat_d  = last_latency;
        min_d       = min_latency;
        max_d       = max_latency;
        lat_valid_d = lat_valid;
        last_int_d  = last_interval;
        busy_d      = busy_cycles;
        stall_d     = stall_cycles;
        lat_d       = lat_q;
        int_d       = int_q;
        seen_d      = seen_q;
        complete    = 1'b0;
        cur_lat     = '0;

        if (!finished) begin
            if (finish) begin
                finished_d = 1'b1;
            end else begin
                case (st_q)
                    ST_IDLE: begin
                        if (hs.ap_start) begin
                            lat_d = '0;
                            st_d  = ST_RUN;
                            if (hs.ap_done) begin
                                complete = 1'b1;
                                cur_lat  = '0;
                                st_d     = hs.ap_continue ? ST_IDLE : ST_WAIT;
                            end
                        end
                    end
                    ST_RUN: begin
                        busy_d = sat_inc(busy_cycles);
                        lat_d  = sat_inc(lat_q);
                        if (hs.ap_done) begin
                            complete = 1'b1;
                            cur_lat  = sat_inc(lat_q);
                            if (!hs.ap_continue) begin
                                st_d = ST_WAIT;
                            end else if (hs.ap_start) begin
                                st_d  = ST_RUN;
                                lat_d = '0;
                            end else begin
                                st_d = ST_IDLE;
                            end
                        end
                    end
                    ST_WAIT: begin
                        stall_d = sat_inc(stall_cycles);
                        if (hs.ap_continue) begin
                            if (hs.ap_start) begin
                                st_d  = ST_RUN;
                                lat_d = '0;
                            end else begin
                                st_d = ST_IDLE;
                            end
                        end
                    end
                    default: st_d = ST_IDLE;
                endcase

                if (complete) begin
                    txn_d       = sat_inc(txn_count);
                    done_d      = 1'b1;
                    last_lat_d  = cur_lat;
                    lat_valid_d = 1'b1;
                    if (cur_lat < min_latency) min_d = cur_lat;
                    if (cur_lat > max_latency) max_d = cur_lat;
                end

                // Ready interval tracking runs regardless of the FSM
                if (hs.ap_ready) begin
                    ready_d = sat_inc(ready_count);
                    if (seen_q) last_int_d = int_q;
                    seen_d = 1'b1;
                    int_d  = CNT_W'(1);
                end else begin
                    int_d = sat_inc(int_q);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q          <= ST_IDLE;
            finished      <= 1'b0;
            done_pulse    <= 1'b0;
            txn_count     <= '0;
            ready_count   <= '0;
            last_latency  <= '0;
            min_latency   <= '1;
            max_latency   <= '0;
            lat_valid     <= 1'b0;
            last_interval <= '0;
            busy_cycles   <= '0;
            stall_cycles  <= '0;
            lat_q         <= '0;
            int_q         <= '0;
            seen_q        <= 1'b0;
        end else begin
            st_q          <= st_d;
            finished      <= finished_d;
            done_pulse    <= done_d;
            txn_count     <= txn_d;
            ready_count   <= ready_d;
            last_latency  <= last_lat_d;
            min_latency   <= min_d;
            max_latency   <= max_d;
            lat_valid     <= lat_valid_d;
            last_interval <= last_int_d;
            busy_cycles   <= busy_d;
            stall_cycles  <= stall_d;
            lat_q         <= lat_d;
            int_q         <= int_d;
            seen_q        <= seen_d;
        end
    end

endmodule

// File: tb/tb_nodf_module_handshake_tracker.sv
// Directed bench for the handshake tracker: cycle table plus corner sequences.
module tb_nodf_module_handshake_tracker;

    logic        clock = 1'b0;
    logic        reset;
    logic        finish;
    logic [1:0]  state;
    logic        finished, done_pulse, lat_valid;
    logic [31:0] txn_count, ready_count, last_latency, min_latency, max_latency;
    logic [31:0] last_interval, busy_cycles, stall_cycles;

    nodf_module_handshake_tracker_if hs ();

    nodf_module_handshake_tracker #(.CNT_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .hs            (hs.slave),
        .finish        (finish),
        .state         (state),
        .finished      (finished),
        .done_pulse    (done_pulse),
        .txn_count     (txn_count),
        .ready_count   (ready_count),
        .last_latency  (last_latency),
        .min_latency   (min_latency),
        .max_latency   (max_latency),
        .lat_valid     (lat_valid),
        .last_interval (last_interval),
        .busy_cycles   (busy_cycles),
        .stall_cycles  (stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, start, done, cont;
        logic [1:0]  st;
        logic        dp;
        logic [31:0] txn, last, busy, stall;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic start, input logic done,
                       input logic cont, input logic [1:0] st, input logic dp,
                       input logic [31:0] txn, input logic [31:0] last,
                       input logic [31:0] busy, input logic [31:0] stall);
        vec_t v;
        v.rst = rst; v.start = start; v.done = done; v.cont = cont;
        v.st = st; v.dp = dp; v.txn = txn; v.last = last;
        v.busy = busy; v.stall = stall;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic start, input logic ready, input logic done,
                         input logic cont, input logic fin);
        hs.ap_start = start; hs.ap_ready = ready; hs.ap_done = done;
        hs.ap_continue = cont; finish = fin;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".state"},    32'(state), 32'd0);
        check({tag, ".txn"},      txn_count, 32'd0);
        check({tag, ".ready"},    ready_count, 32'd0);
        check({tag, ".last"},     last_latency, 32'd0);
        check({tag, ".min"},      min_latency, 32'hFFFF_FFFF);
        check({tag, ".max"},      max_latency, 32'd0);
        check({tag, ".latv"},     32'(lat_valid), 32'd0);
        check({tag, ".intv"},     last_interval, 32'd0);
        check({tag, ".busy"},     busy_cycles, 32'd0);
        check({tag, ".stall"},    stall_cycles, 32'd0);
        check({tag, ".finished"}, 32'(finished), 32'd0);
        check({tag, ".dp"},       32'(done_pulse), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single transaction, done 5 cycles after start, continue tied high
        add(0,1,0,1, 2'd1,0, 1,0,0,0);
        tbl[$].txn = 0;
        add(0,0,0,1, 2'd1,0, 0,0,1,0);
        add(0,0,0,1, 2'd1,0, 0,0,2,0);
        add(0,0,0,1, 2'd1,0, 0,0,3,0);
        add(0,0,0,1, 2'd1,0, 0,0,4,0);
        add(0,0,1,1, 2'd0,1, 1,5,5,0);
        add(0,0,0,1, 2'd0,0, 1,5,5,0);
        // Done with continue withheld for three cycles
        add(0,1,0,0, 2'd1,0, 1,5,5,0);
        add(0,0,0,0, 2'd1,0, 1,5,6,0);
        add(0,0,1,0, 2'd2,1, 2,2,7,0);
        add(0,0,0,0, 2'd2,0, 2,2,7,1);
        add(0,0,0,0, 2'd2,0, 2,2,7,2);
        add(0,0,0,1, 2'd0,0, 2,2,7,3);
        // Reset, then back-to-back latencies 4 and 7
        add(1,0,0,0, 2'd0,0, 0,0,0,0);
        add(0,1,0,1, 2'd1,0, 0,0,0,0);
        add(0,0,0,1, 2'd1,0, 0,0,1,0);
        add(0,0,0,1, 2'd1,0, 0,0,2,0);
        add(0,0,0,1, 2'd1,0, 0,0,3,0);
        add(0,1,1,1, 2'd1,1, 1,4,4,0);
        for (int k = 5; k <= 10; k++) add(0,0,0,1, 2'd1,0, 1,4,32'(k),0);
        add(0,0,1,1, 2'd0,1, 2,7,11,0);

        step(); step();
        reset = 1'b0;
        check_reset_state("rst");

        for (int i = 0; i < 50; i++) step();
        check_reset_state("idle50");

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            drive(tbl[i].start, 1'b0, tbl[i].done, tbl[i].cont, 1'b0);
            step();
            check($sformatf("row%0d.state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("row%0d.dp", i),    32'(done_pulse), 32'(tbl[i].dp));
            check($sformatf("row%0d.txn", i),   txn_count, tbl[i].txn);
            check($sformatf("row%0d.last", i),  last_latency, tbl[i].last);
            check($sformatf("row%0d.busy", i),  busy_cycles, tbl[i].busy);
            check($sformatf("row%0d.stall", i), stall_cycles, tbl[i].stall);
        end
        reset = 1'b0;
        check("b2b.min",  min_latency, 32'd4);
        check("b2b.max",  max_latency, 32'd7);
        check("b2b.latv", 32'(lat_valid), 32'd1);

        // Ready-only wiring: pulses at 10, 16, 17
        reset = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            hs.ap_ready = (i == 10 || i == 16 || i == 17);
            step();
            if (i == 10) check("rdy.first_intv", last_interval, 32'd0);
            if (i == 16) check("rdy.intv6", last_interval, 32'd6);
            if (i == 17) check("rdy.intv1", last_interval, 32'd1);
        end
        check("rdy.count", ready_count, 32'd3);
        check("rdy.state", 32'(state), 32'd0);
        check("rdy.txn",   txn_count, 32'd0);

        // Done in IDLE without start is ignored; start+done in IDLE is latency 0
        reset = 1'b1; step(); reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0); step();
        check("idle_done.txn", txn_count, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); step();
        check("lat0.dp",   32'(done_pulse), 32'd1);
        check("lat0.txn",  txn_count, 32'd1);
        check("lat0.min",  min_latency, 32'd0);
        check("lat0.latv", 32'(lat_valid), 32'd1);

        // finish mid-RUN freezes everything
        reset = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step(); reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step(); step();
        check("fin.busy_pre", busy_cycles, 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); step();
        check("fin.finished", 32'(finished), 32'd1);
        check("fin.busy_hold", busy_cycles, 32'd2);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("frz.finished", 32'(finished), 32'd1);
        check("frz.state", 32'(state), 32'd1);
        check("frz.busy",  busy_cycles, 32'd2);
        check("frz.txn",   txn_count, 32'd0);
        check("frz.ready", ready_count, 32'd0);
        check("frz.dp",    32'(done_pulse), 32'd0);
        check("frz.latv",  32'(lat_valid), 32'd0);

        // Reset beats a simultaneous finish and clears the sticky flag
        reset = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        reset = 1'b0; drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_reset_state("post_fin_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
